sync_multi_fifo: RTL and testbench

//  Parametrised successor to the single-word two-flop 4-phase link. Words enter a DEPTH-entry

---
 rtl/sync_multi_fifo.sv | 201 ++++++++++++++++++++
 tb/tb_sync_multi_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_multi_fifo.sv
// rtl/sync_multi_fifo.sv - buffered 4-phase req/ack word link with synchronised handshake paths
//
// Purpose: words from a bursty producer are queued in a DEPTH-entry FIFO, then
// sent one at a time to a receiver over a req/ack 4-phase handshake. Each
// handshake direction passes through a SYNC_STAGES-deep flop chain.
//
// Ports:
//   clk       in   1           clock, rising edge
//   reset     in   1           synchronous, active-high
//   in_data   in   DATA_WIDTH  word to send, sampled when v=1
//   v         in   1           write strobe, accepted only while f=0
//   out_data  out  DATA_WIDTH  last delivered word, held until the next delivery
//   d         out  1           one-cycle pulse: out_data updated this cycle
//   f         out  1           FIFO full (cnt==DEPTH)
//   busy      out  1           FIFO non-empty or either handshake FSM active
//   ovf       out  1           sticky: a word was dropped because the FIFO was full
//   cnt       out  CNT_W       FIFO occupancy
module sync_multi_fifo #(
    parameter int  DATA_WIDTH  = 8,
    parameter int  DEPTH       = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  v,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  d,
    output logic                  f,
    output logic                  busy,
    output logic                  ovf,
    output logic [CNT_W-1:0]      cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_REL} tx_state_t;
    typedef enum logic       {RX_IDLE, RX_ACK}         rx_state_t;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_full;
    logic                  r_ovf;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_not_empty;

    // Handshake
    tx_state_t             r_tx_state;
    tx_state_t             w_tx_next;
    rx_state_t             r_rx_state;
    rx_state_t             w_rx_next;
    logic                  r_req;
    logic                  r_ack;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                  w_req_s;
    logic                  w_ack_s;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  w_rx_capture;

    // Receiver side outputs
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_d;

    assign w_not_empty = (r_cnt != '0);
    assign w_push      = v && !r_full;
    assign w_cnt_nxt   = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_req_s     = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s     = r_ack_sync[SYNC_STAGES-1];

    //------------------------------------------------------------------
    // FIFO
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == CNT_W'(DEPTH));
            if (v && r_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    //------------------------------------------------------------------
    // Synchronisers: req toward the receiver, ack back toward the sender
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], r_req};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
        end
    end

    //------------------------------------------------------------------
    // TX FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_req      <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            // req is high exactly while the sender waits in REQ
            r_req      <= (w_tx_next == TX_REQ);
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
        end
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (w_not_empty) w_tx_next = TX_REQ;
            TX_REQ:  if (w_ack_s)     w_tx_next = TX_REL;
            TX_REL:  if (!w_ack_s)    w_tx_next = w_not_empty ? TX_REQ : TX_IDLE;
            default:                  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        w_pop = 1'b0;
        case (r_tx_state)
            TX_IDLE: w_pop = w_not_empty;
            TX_REL:  w_pop = !w_ack_s && w_not_empty;
            default: w_pop = 1'b0;
        endcase
    end

    //------------------------------------------------------------------
    // RX FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_ack      <= 1'b0;
            r_d        <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_ack      <= (w_rx_next == RX_ACK);
            r_d        <= w_rx_capture;
            // tx_data has been stable since the pop, well before req_s arrives
            if (w_rx_capture) begin
                r_out_data <= r_tx_data;
            end
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE: if (w_req_s)  w_rx_next = RX_ACK;
            RX_ACK:  if (!w_req_s) w_rx_next = RX_IDLE;
            default:               w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_capture = (r_rx_state == RX_IDLE) && w_req_s;
    end

    //------------------------------------------------------------------
    // Outputs
    //------------------------------------------------------------------
    assign out_data = r_out_data;
    assign d        = r_d;
    assign f        = r_full;
    assign ovf      = r_ovf;
    assign cnt      = r_cnt;
    assign busy     = w_not_empty || (r_tx_state != TX_IDLE) || (r_rx_state != RX_IDLE);

endmodule

// File: tb/tb_sync_multi_fifo.sv
// tb/tb_sync_multi_fifo.sv - scoreboard bench for sync_multi_fifo
module tb_sync_multi_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // S=2, 8-bit instance
    logic [7:0]  in_data = '0;
    logic        v = 1'b0;
    logic [7:0]  out_data;
    logic        d, f, busy, ovf;
    logic [2:0]  cnt;

    // S=3, 16-bit instance
    logic [15:0] in_data3 = '0;
    logic        v3 = 1'b0;
    logic [15:0] out_data3;
    logic        d3, f3, busy3, ovf3;
    logic [2:0]  cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] sb_q[$];
    logic [15:0] sb_q3[$];
    int          d_times[$];
    int          d_times3[$];
    int          n_deliv  = 0;
    int          n_deliv3 = 0;

    sync_multi_fifo #(.DATA_WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .v(v),
        .out_data(out_data), .d(d), .f(f), .busy(busy), .ovf(ovf), .cnt(cnt)
    );

    sync_multi_fifo #(.DATA_WIDTH(16), .DEPTH(4), .SYNC_STAGES(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .v(v3),
        .out_data(out_data3), .d(d3), .f(f3), .busy(busy3), .ovf(ovf3), .cnt(cnt3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboards: every delivery must match the oldest outstanding accepted word
    always @(negedge clk) begin
        if (d) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'(sb_q.size()), 32'd1);
            else check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
            d_times.push_back(cyc);
            n_deliv++;
        end
        if (d3) begin
            if (sb_q3.size() == 0) check("sb3_underflow", 32'(sb_q3.size()), 32'd1);
            else check("sb3_data", 32'(out_data3), 32'(sb_q3.pop_front()));
            d_times3.push_back(cyc);
            n_deliv3++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        sb_q.delete();
        sb_q3.delete();
        d_times.delete();
        d_times3.delete();
        n_deliv  = 0;
        n_deliv3 = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v = 1'b0;
        v3 = 1'b0;
        step();
        step();
        reset = 1'b0;
        clear_sb();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_out_data", 32'(out_data), 0);
        check("rst_d", 32'(d), 0);
        check("rst_f", 32'(f), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_cnt", 32'(cnt), 0);

        // T1: single word latency and busy release
        v = 1'b1; in_data = 8'hA5; sb_q.push_back(16'hA5);
        step();                               // edge 0
        v = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 3)  check("t1_d_early", 32'(d), 0);
            if (k == 4) begin
                check("t1_d_pulse", 32'(d), 1);
                check("t1_out_data", 32'(out_data), 32'hA5);
            end
            if (k == 5)  check("t1_d_one_cycle", 32'(d), 0);
            if (k == 12) check("t1_busy_held", 32'(busy), 1);
            if (k == 13) check("t1_busy_fall", 32'(busy), 0);
        end
        check("t1_deliveries", 32'(n_deliv), 1);

        // T2: four words back-to-back, no overflow, 12-cycle spacing
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v = 1'b1; in_data = 8'(i + 1); sb_q.push_back(16'(i + 1));
            step();
            check("t2_f_low", 32'(f), 0);
        end
        v = 1'b0;
        repeat (60) step();
        check("t2_deliveries", 32'(n_deliv), 4);
        for (int i = 1; i < d_times.size(); i++)
            check("t2_period", 32'(d_times[i] - d_times[i-1]), 12);
        check("t2_ovf", 32'(ovf), 0);
        check("t2_busy_end", 32'(busy), 0);

        // T3: six words, sixth dropped on full, ovf sticky
        do_reset();
        for (int i = 0; i < 6; i++) begin
            v = 1'b1; in_data = 8'(8'h10 + i);
            if (i < 5) sb_q.push_back(16'(8'h10 + i));
            step();
            if (i == 4) begin
                check("t3_f_full", 32'(f), 1);
                check("t3_ovf_before", 32'(ovf), 0);
                check("t3_cnt_full", 32'(cnt), 4);
            end
            if (i == 5) check("t3_ovf_set", 32'(ovf), 1);
        end
        v = 1'b0;
        repeat (75) step();
        check("t3_deliveries", 32'(n_deliv), 5);
        check("t3_ovf_sticky", 32'(ovf), 1);
        check("t3_busy_end", 32'(busy), 0);

        // T4: push coincides with pop at cnt=2
        do_reset();
        for (int i = 0; i < 3; i++) begin
            v = 1'b1; in_data = 8'(8'h11 * (i + 1)); sb_q.push_back(16'(8'h11 * (i + 1)));
            step();                           // edges 0..2
        end
        v = 1'b0;
        repeat (10) step();                   // edges 3..12
        check("t4_cnt_before", 32'(cnt), 2);
        v = 1'b1; in_data = 8'h44; sb_q.push_back(16'h44);
        step();                               // edge 13: push and pop together
        v = 1'b0;
        check("t4_cnt_same", 32'(cnt), 2);
        repeat (50) step();
        check("t4_deliveries", 32'(n_deliv), 4);
        check("t4_cnt_end", 32'(cnt), 0);

        // T5: reset mid-handshake (TX in REQ, RX in ACK)
        do_reset();
        v = 1'b1; in_data = 8'h5A; sb_q.push_back(16'h5A);
        step();                               // edge 0
        v = 1'b0;
        repeat (5) step();                    // edges 1..5
        check("t5_busy_mid", 32'(busy), 1);
        reset = 1'b1;
        step();                               // edge 6: reset sampled
        check("t5_out_data", 32'(out_data), 0);
        check("t5_d", 32'(d), 0);
        check("t5_f", 32'(f), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_ovf", 32'(ovf), 0);
        check("t5_cnt", 32'(cnt), 0);
        reset = 1'b0;
        clear_sb();
        v = 1'b1; in_data = 8'h77; sb_q.push_back(16'h77);
        step();                               // edge 0
        v = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) check("t5_d_early", 32'(d), 0);
            if (k == 4) begin
                check("t5_d_pulse", 32'(d), 1);
                check("t5_out_data_new", 32'(out_data), 32'h77);
            end
        end
        repeat (15) step();
        check("t5_deliveries", 32'(n_deliv), 1);

        // T6: SYNC_STAGES=3, 16-bit data
        do_reset();
        v3 = 1'b1; in_data3 = 16'hBEEF; sb_q3.push_back(16'hBEEF);
        step();                               // edge 0
        in_data3 = 16'h1234; sb_q3.push_back(16'h1234);
        step();                               // edge 1
        v3 = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            if (k == 4) check("t6_d_early", 32'(d3), 0);
            if (k == 5) begin
                check("t6_d_pulse", 32'(d3), 1);
                check("t6_out_data", 32'(out_data3), 32'hBEEF);
            end
        end
        repeat (40) step();
        check("t6_deliveries", 32'(n_deliv3), 2);
        if (d_times3.size() >= 2)
            check("t6_period", 32'(d_times3[1] - d_times3[0]), 16);
        check("t6_busy_end", 32'(busy3), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
